// File: rtl/alu_ctrl_seq.sv
// ALU control decode plus iterative multiply/divide sequencer driving HI/LO.
// Define ALU_CTRL_DIV_EN to build the restoring divider (DIV/DIVU); otherwise those functs decode illegal.
module alu_ctrl_seq #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] HILO_RST = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             brk_clr,
  output logic [2:0]       alu_sel,
  output logic             illegal,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             break_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d, done_q, done_d, brk_q, brk_d;
  logic               dz_flag_q, dz_flag_d;
`ifdef ALU_CTRL_DIV_EN
  logic               div_q, div_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH:0]     dshift, ddiff;
  logic               dge;
`endif

  logic               is_r, md_funct, accept, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    alu_sel = 3'b001;
    illegal = 1'b0;
    if (alu_op == 3'b001) alu_sel = 3'b010;
    else if (alu_op == 3'b010) begin
      case (funct)
        6'h20, 6'h21: alu_sel = 3'b001;
        6'h22, 6'h23: alu_sel = 3'b010;
        6'h24:        alu_sel = 3'b011;
        6'h25:        alu_sel = 3'b100;
        6'h26:        alu_sel = 3'b110;
        6'h27:        alu_sel = 3'b101;
        6'h2a:        alu_sel = 3'b111;
        6'h0d, 6'h18, 6'h19: ;
`ifdef ALU_CTRL_DIV_EN
        6'h1a, 6'h1b: ;
`endif
        default:      illegal = 1'b1;
      endcase
    end
  end

  assign is_r = start && (alu_op == 3'b010);
`ifdef ALU_CTRL_DIV_EN
  assign md_funct = (funct[5:2] == 4'b0110);
`else
  assign md_funct = (funct == 6'h18) || (funct == 6'h19);
`endif
  assign accept = is_r && md_funct && (state_q == IDLE);

  // Even functs (0x18/0x1a) are the signed variants.
  assign a_neg = ~funct[0] & op_a[WIDTH-1];
  assign b_neg = ~funct[0] & op_b[WIDTH-1];
  assign abs_a = a_neg ? -op_a : op_a;
  assign abs_b = b_neg ? -op_b : op_b;

  assign msum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
  assign prod = {rem_q, quo_q};
`ifdef ALU_CTRL_DIV_EN
  assign dshift = {rem_q, quo_q[WIDTH-1]};
  assign ddiff  = dshift - {1'b0, b_q};
  assign dge    = dshift >= {1'b0, b_q};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    b_d       = b_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_flag_d = dz_flag_q;
`ifdef ALU_CTRL_DIV_EN
    div_d  = div_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d   = RUN;
        cnt_d     = '0;
        rem_d     = '0;
        quo_d     = abs_a;
        b_d       = abs_b;
        neg_d     = a_neg ^ b_neg;
        dz_flag_d = 1'b0;
`ifdef ALU_CTRL_DIV_EN
        div_d  = funct[1];
        rneg_d = a_neg;
        dz_d   = funct[1] && (op_b == '0);
`endif
      end
      RUN: begin
`ifdef ALU_CTRL_DIV_EN
        if (div_q && dz_q) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          dz_flag_d = 1'b1;
        end else if (div_q) begin
          rem_d = dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], dge};
        end else
`endif
        begin
          rem_d = msum[WIDTH:1];
          quo_d = {msum[0], quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        {hi_d, lo_d} = neg_q ? -prod : prod;
`ifdef ALU_CTRL_DIV_EN
        if (div_q) begin
          lo_d = neg_q  ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Set wins over a simultaneous clear.
  assign brk_d = (is_r && funct == 6'h0d) ? 1'b1 : (brk_clr ? 1'b0 : brk_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      hi_q      <= HILO_RST;
      lo_q      <= HILO_RST;
      done_q    <= 1'b0;
      dz_flag_q <= 1'b0;
      brk_q     <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
      div_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_flag_q <= dz_flag_d;
      brk_q     <= brk_d;
`ifdef ALU_CTRL_DIV_EN
      div_q  <= div_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
`endif
    end
  end

  assign md_busy  = (state_q != IDLE);
  assign md_done  = done_q;
  assign div_zero = dz_flag_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign break_o  = brk_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode table plus multi-cycle mult/div/break/reset sequences.
module tb_alu_ctrl_seq;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [2:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic        start = 1'b0, brk_clr = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [2:0]  alu_sel;
  logic        illegal, md_busy, md_done, div_zero, break_o;
  logic [31:0] hi, lo;

  int checks = 0, errors = 0;

  alu_ctrl_seq #(.WIDTH(32), .HILO_RST(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .alu_op(alu_op), .funct(funct), .start(start),
    .op_a(op_a), .op_b(op_b), .brk_clr(brk_clr), .alu_sel(alu_sel), .illegal(illegal),
    .md_busy(md_busy), .md_done(md_done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .break_o(break_o)
  );

  always #5 clk = ~clk;

`ifdef ALU_CTRL_DIV_EN
  localparam logic DIV_ILL = 1'b0;
`else
  localparam logic DIV_ILL = 1'b1;
`endif

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [2:0] sel;
    logic       ill;
  } dec_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns edges from accept to md_done (100 on timeout); optional stray start at cycle inj.
  task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int edges);
    alu_op = 3'b010; funct = fn; op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_accept", {63'b0, md_busy}, 64'd1);
    edges = 0;
    while (!md_done && edges < 100) begin
      start = (edges == inj);
      if (edges == inj) begin op_a = 32'h1234_5678; op_b = 32'h9; funct = 6'h18; end
      step();
      start = 1'b0;
      edges++;
    end
  endtask

  dec_vec_t dv[19];
  int e;

  initial begin
    dv[0]  = '{3'b010, 6'h24, 3'b011, 1'b0};
    dv[1]  = '{3'b010, 6'h3f, 3'b001, 1'b1};
    dv[2]  = '{3'b001, 6'h2a, 3'b010, 1'b0};
    dv[3]  = '{3'b000, 6'h3f, 3'b001, 1'b0};
    dv[4]  = '{3'b111, 6'h22, 3'b001, 1'b0};
    dv[5]  = '{3'b011, 6'h00, 3'b001, 1'b0};
    dv[6]  = '{3'b010, 6'h20, 3'b001, 1'b0};
    dv[7]  = '{3'b010, 6'h21, 3'b001, 1'b0};
    dv[8]  = '{3'b010, 6'h22, 3'b010, 1'b0};
    dv[9]  = '{3'b010, 6'h23, 3'b010, 1'b0};
    dv[10] = '{3'b010, 6'h25, 3'b100, 1'b0};
    dv[11] = '{3'b010, 6'h26, 3'b110, 1'b0};
    dv[12] = '{3'b010, 6'h27, 3'b101, 1'b0};
    dv[13] = '{3'b010, 6'h2a, 3'b111, 1'b0};
    dv[14] = '{3'b010, 6'h0d, 3'b001, 1'b0};
    dv[15] = '{3'b010, 6'h18, 3'b001, 1'b0};
    dv[16] = '{3'b010, 6'h19, 3'b001, 1'b0};
    dv[17] = '{3'b010, 6'h1a, 3'b001, DIV_ILL};
    dv[18] = '{3'b010, 6'h00, 3'b001, 1'b1};

    #12;
    check("rst_busy", {63'b0, md_busy}, 64'd0);
    check("rst_done", {63'b0, md_done}, 64'd0);
    check("rst_dz", {63'b0, div_zero}, 64'd0);
    check("rst_brk", {63'b0, break_o}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      alu_op = dv[i].op; funct = dv[i].fn;
      #1;
      check($sformatf("dec_sel[%0d]", i), {61'b0, alu_sel}, {61'b0, dv[i].sel});
      check($sformatf("dec_ill[%0d]", i), {63'b0, illegal}, {63'b0, dv[i].ill});
    end
    alu_op = 3'b000; funct = 6'h00;
    step();

    // signed mult -3 * 7
    run_md(6'h18, 32'hFFFF_FFFD, 32'd7, -1, e);
    check("mult_latency", 64'(e), 64'd33);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_busy_at_done", {63'b0, md_busy}, 64'd0);
    step();
    check("done_one_cycle", {63'b0, md_done}, 64'd0);

    // unsigned max*max with a stray start during the run
    run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, e);
    check("multu_latency", 64'(e), 64'd33);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    step();
    check("no_restart", {63'b0, md_busy}, 64'd0);

    // reset mid-multiply
    alu_op = 3'b010; funct = 6'h18; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {63'b0, md_busy}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    step();
    reset_n = 1'b1;
    step();
    run_md(6'h19, 32'd3, 32'd4, -1, e);
    check("post_rst_latency", 64'(e), 64'd33);
    check("post_rst_hilo", {hi, lo}, 64'd12);

`ifdef ALU_CTRL_DIV_EN
    run_md(6'h1a, 32'hFFFF_FFF9, 32'd2, -1, e);
    check("div_latency", 64'(e), 64'd33);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_dz_clear", {63'b0, div_zero}, 64'd0);
    run_md(6'h1a, 32'd5, 32'd0, -1, e);
    check("dz_latency", 64'(e), 64'd1);
    check("dz_flag", {63'b0, div_zero}, 64'd1);
    check("dz_busy", {63'b0, md_busy}, 64'd0);
    check("dz_hilo_held", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, -1, e);
    check("minneg1_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    check("minneg1_dz", {63'b0, div_zero}, 64'd0);
    run_md(6'h1b, 32'd100, 32'd7, -1, e);
    check("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
`else
    alu_op = 3'b010; funct = 6'h1b; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    #1;
    check("nodiv_illegal", {63'b0, illegal}, 64'd1);
    step();
    start = 1'b0;
    check("nodiv_busy", {63'b0, md_busy}, 64'd0);
    step();
    check("nodiv_hilo", {hi, lo}, 64'd12);
    check("nodiv_dz", {63'b0, div_zero}, 64'd0);
`endif

    // sticky break flag
    alu_op = 3'b010; funct = 6'h0d; start = 1'b1;
    step();
    start = 1'b0;
    check("brk_set", {63'b0, break_o}, 64'd1);
    repeat (3) step();
    check("brk_hold", {63'b0, break_o}, 64'd1);
    start = 1'b1; brk_clr = 1'b1;
    step();
    start = 1'b0;
    check("brk_set_wins", {63'b0, break_o}, 64'd1);
    step();
    brk_clr = 1'b0;
    check("brk_clr", {63'b0, break_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
